// File: rtl/intr_ctl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and register offsets.
package intr_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_e;

    localparam int OFF_IEN    = 0;
    localparam int OFF_IPEND  = 4;
    localparam int OFF_ICLAIM = 8;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending sources.
module intr_prio_enc #(
    parameter int NSRC = 4,
    parameter int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0] req,
    output logic [IDXW-1:0] idx,
    output logic            valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Scan downwards so the last hit, the lowest index, is the one kept.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctl.sv
// Bus-mapped interrupt controller: edge-latched pending bits, enables, one claim at a time.
module intr_ctl
    import intr_ctl_pkg::*;
#(
    parameter int              BITS = 32,
    parameter logic [BITS-1:0] BASE = 32'hF0000100,
    parameter int              NSRC = 4
) (
    input  logic            CLK,
    input  logic            INIT_N,
    input  logic [BITS-1:0] ABUS,
    inout  wire  [BITS-1:0] DBUS,
    input  logic            WE,
    input  logic [NSRC-1:0] IRQ_IN,
    input  logic            INTA,
    output logic            INTR
);

    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

    localparam logic [BITS-1:0] A_IEN    = BASE + BITS'(OFF_IEN);
    localparam logic [BITS-1:0] A_IPEND  = BASE + BITS'(OFF_IPEND);
    localparam logic [BITS-1:0] A_ICLAIM = BASE + BITS'(OFF_ICLAIM);

    state_e          state_q, state_d;
    logic [NSRC-1:0] ien_q, ien_d;
    logic            gie_q, gie_d;
    logic [NSRC-1:0] ipend_q, ipend_d;
    logic [NSRC-1:0] irq_q;
    logic            armed_q;
    logic [BITS-2:0] claim_q, claim_d;

    logic            hit_ien, hit_ipend, hit_iclaim;
    logic            wr_ien, wr_ipend, wr_iclaim, rd_en;
    logic [NSRC-1:0] rise, wr_clr, claim_clr, active;
    logic [IDXW-1:0] enc_idx;
    logic            enc_valid, qualify;
    logic [BITS-1:0] rd_data;

    assign hit_ien    = (ABUS == A_IEN);
    assign hit_ipend  = (ABUS == A_IPEND);
    assign hit_iclaim = (ABUS == A_ICLAIM);
    assign wr_ien     = WE && hit_ien;
    assign wr_ipend   = WE && hit_ipend;
    assign wr_iclaim  = WE && hit_iclaim;
    assign rd_en      = !WE && (hit_ien || hit_ipend || hit_iclaim);

    // armed_q blanks the first edge after reset so a line held high through
    // reset is captured into irq_q without being mistaken for a new request.
    assign rise   = IRQ_IN & ~irq_q & {NSRC{armed_q}};
    assign active = ipend_q & ien_q;
    assign wr_clr = wr_ipend ? DBUS[NSRC-1:0] : '0;

    intr_prio_enc #(
        .NSRC (NSRC),
        .IDXW (IDXW)
    ) u_prio_enc (
        .req   (active),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign qualify = gie_q && enc_valid;
    assign INTR    = (state_q == ST_REQ);

    always_comb begin
        state_d   = state_q;
        ien_d     = ien_q;
        gie_d     = gie_q;
        claim_d   = claim_q;
        claim_clr = '0;

        if (wr_ien) begin
            ien_d = DBUS[NSRC-1:0];
            gie_d = DBUS[BITS-1];
        end

        case (state_q)
            ST_IDLE: begin
                if (qualify) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!qualify) begin
                    state_d = ST_IDLE;
                end else if (INTA) begin
                    state_d   = ST_SERV;
                    claim_d   = (BITS-1)'(enc_idx);
                    claim_clr = NSRC'(1) << enc_idx;
                end
            end
            ST_SERV: begin
                if (wr_iclaim) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // New edges are OR'd in last so they survive a same-cycle clear.
        ipend_d = (ipend_q & ~wr_clr & ~claim_clr) | rise;
    end

    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            state_q <= ST_IDLE;
            ien_q   <= '0;
            gie_q   <= 1'b0;
            ipend_q <= '0;
            irq_q   <= '0;
            armed_q <= 1'b0;
            claim_q <= '0;
        end else begin
            state_q <= state_d;
            ien_q   <= ien_d;
            gie_q   <= gie_d;
            ipend_q <= ipend_d;
            irq_q   <= IRQ_IN;
            armed_q <= 1'b1;
            claim_q <= claim_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit_ien) begin
            rd_data[NSRC-1:0] = ien_q;
            rd_data[BITS-1]   = gie_q;
        end else if (hit_ipend) begin
            rd_data[NSRC-1:0] = ipend_q;
        end else if (hit_iclaim) begin
            rd_data = {(state_q == ST_SERV), claim_q};
        end
    end

    assign DBUS = rd_en ? rd_data : {BITS{1'bz}};

endmodule

// File: tb/tb_intr_ctl.sv
// Self-checking bench for intr_ctl: register table plus directed interrupt sequences.
module tb_intr_ctl;

    localparam logic [31:0] BASE   = 32'hF0000100;
    localparam logic [31:0] A_IEN  = BASE;
    localparam logic [31:0] A_PEND = BASE + 32'd4;
    localparam logic [31:0] A_CLM  = BASE + 32'd8;
    localparam logic [31:0] A_NONE = BASE + 32'd12;

    logic        CLK;
    logic        INIT_N;
    logic [31:0] ABUS;
    wire  [31:0] DBUS;
    logic        WE;
    logic [3:0]  IRQ_IN;
    logic        INTA;
    logic        INTR;

    logic [31:0] drv;
    logic        oe;
    assign DBUS = oe ? drv : {32{1'bz}};

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] exp_ien;
    } ien_vec_t;
    ien_vec_t vecs[5];

    intr_ctl #(.BITS(32), .BASE(BASE), .NSRC(4)) dut (
        .CLK    (CLK),
        .INIT_N (INIT_N),
        .ABUS   (ABUS),
        .DBUS   (DBUS),
        .WE     (WE),
        .IRQ_IN (IRQ_IN),
        .INTA   (INTA),
        .INTR   (INTR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        ABUS = a;
        drv  = d;
        oe   = 1'b1;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        oe   = 1'b0;
        ABUS = 32'h0;
    endtask

    task automatic read_expect(input logic [31:0] a, input logic [31:0] e, input string nm);
        logic [31:0] got;
        logic [31:0] ex;
        exp_q.push_back(e);
        ABUS = a;
        WE   = 1'b0;
        oe   = 1'b0;
        #1;
        got  = DBUS;
        ex   = exp_q.pop_front();
        check(nm, got, ex);
        ABUS = 32'h0;
    endtask

    task automatic check_intr(input logic e, input string nm);
        check(nm, {31'd0, INTR}, {31'd0, e});
    endtask

    task automatic pulse_inta();
        INTA = 1'b1;
        tick();
        INTA = 1'b0;
    endtask

    task automatic apply_reset();
        INIT_N = 1'b0;
        IRQ_IN = '0;
        repeat (2) tick();
        INIT_N = 1'b1;
        tick();
    endtask

    initial begin
        INIT_N = 1'b0;
        ABUS   = 32'h0;
        WE     = 1'b0;
        IRQ_IN = '0;
        INTA   = 1'b0;
        drv    = 32'h0;
        oe     = 1'b0;

        vecs[0] = '{32'hFFFFFFFF, 32'h8000000F};
        vecs[1] = '{32'h00000005, 32'h00000005};
        vecs[2] = '{32'h800000F0, 32'h80000000};
        vecs[3] = '{32'h7FFFFFF0, 32'h00000000};
        vecs[4] = '{32'h0000000A, 32'h0000000A};

        apply_reset();
        read_expect(A_IEN, 32'h0, "rst_ien");
        read_expect(A_PEND, 32'h0, "rst_ipend");
        read_expect(A_CLM, 32'h0, "rst_iclaim");
        check_intr(1'b0, "rst_intr");

        // IEN masking of unused bits, no IRQ activity
        for (int i = 0; i < 5; i++) begin
            bus_write(A_IEN, vecs[i].wdata);
            read_expect(A_IEN, vecs[i].exp_ien, $sformatf("ien_vec%0d", i));
        end

        // Basic claim of the timer source
        apply_reset();
        bus_write(A_IEN, 32'h80000001);
        IRQ_IN = 4'b0001;
        tick();
        IRQ_IN = 4'b0000;
        read_expect(A_PEND, 32'h1, "t30_ipend_set");
        check_intr(1'b0, "t30_intr_early");
        tick();
        check_intr(1'b1, "t30_intr_high");
        pulse_inta();
        read_expect(A_CLM, 32'h80000000, "t30_iclaim");
        read_expect(A_PEND, 32'h0, "t30_ipend_clr");
        check_intr(1'b0, "t30_intr_low");
        pulse_inta();
        read_expect(A_CLM, 32'h80000000, "t30_inta_in_serv");
        bus_write(A_CLM, 32'h0);
        read_expect(A_CLM, 32'h00000000, "t30_eoi");

        // Two simultaneous sources: lowest index first, second after EOI
        apply_reset();
        bus_write(A_IEN, 32'h80000006);
        IRQ_IN = 4'b0110;
        repeat (2) tick();
        check_intr(1'b1, "t31_intr1");
        pulse_inta();
        read_expect(A_CLM, 32'h80000001, "t31_claim1");
        read_expect(A_PEND, 32'h4, "t31_pend_left");
        bus_write(A_CLM, 32'h0);
        check_intr(1'b0, "t31_intr_eoi");
        read_expect(A_CLM, 32'h00000001, "t31_idx_kept");
        tick();
        check_intr(1'b1, "t31_intr2");
        pulse_inta();
        read_expect(A_CLM, 32'h80000002, "t31_claim2");
        bus_write(A_CLM, 32'h0);
        tick();
        check_intr(1'b0, "t31_idle");
        IRQ_IN = 4'b0000;

        // GIE gating, then GIE drop while requesting, then INTA in IDLE
        apply_reset();
        bus_write(A_IEN, 32'h00000001);
        IRQ_IN = 4'b0001;
        repeat (3) tick();
        read_expect(A_PEND, 32'h1, "t32_pend");
        check_intr(1'b0, "t32_no_gie");
        bus_write(A_IEN, 32'h80000001);
        tick();
        check_intr(1'b1, "t32_gie_on");
        bus_write(A_IEN, 32'h00000001);
        tick();
        check_intr(1'b0, "t32_gie_drop");
        pulse_inta();
        read_expect(A_CLM, 32'h0, "t32_inta_idle");
        read_expect(A_PEND, 32'h1, "t32_pend_kept");
        IRQ_IN = 4'b0000;

        // Set and W1C on the same edge: set wins; plain W1C afterwards clears
        apply_reset();
        IRQ_IN = 4'b0001;
        bus_write(A_PEND, 32'h1);
        read_expect(A_PEND, 32'h1, "t33_set_wins");
        bus_write(A_PEND, 32'h1);
        read_expect(A_PEND, 32'h0, "t33_w1c");
        IRQ_IN = 4'b0000;

        // Reset while in service with a source held high
        apply_reset();
        bus_write(A_IEN, 32'h80000008);
        IRQ_IN = 4'b1000;
        repeat (2) tick();
        pulse_inta();
        read_expect(A_CLM, 32'h80000003, "t34_claim");
        INIT_N = 1'b0;
        #1;
        check_intr(1'b0, "t34_rst_intr");
        read_expect(A_IEN, 32'h0, "t34_rst_ien");
        read_expect(A_PEND, 32'h0, "t34_rst_pend");
        read_expect(A_CLM, 32'h0, "t34_rst_claim");
        tick();
        INIT_N = 1'b1;
        repeat (2) tick();
        read_expect(A_PEND, 32'h0, "t34_no_edge");
        bus_write(A_IEN, 32'h80000008);
        tick();
        check_intr(1'b0, "t34_intr_quiet");
        IRQ_IN = 4'b0000;
        tick();
        IRQ_IN = 4'b1000;
        tick();
        read_expect(A_PEND, 32'h8, "t34_new_edge");
        tick();
        check_intr(1'b1, "t34_intr_again");

        // Unmapped address: not driven on read, ignored on write
        apply_reset();
        bus_write(A_IEN, 32'h80000004);
        ABUS = A_NONE;
        WE   = 1'b0;
        #1;
        checks++;
        if (!(DBUS === {32{1'bz}} || DBUS === 32'h0)) begin
            errors++;
            $display("FAIL t35_unmapped_read got %h exp z", DBUS);
        end
        ABUS = 32'h0;
        bus_write(A_NONE, 32'hFFFFFFFF);
        read_expect(A_IEN, 32'h80000004, "t35_ien_same");
        read_expect(A_PEND, 32'h0, "t35_pend_same");
        read_expect(A_CLM, 32'h0, "t35_claim_same");
        check_intr(1'b0, "t35_intr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
